lsu_misalign_unit: RTL and testbench

Load/store sequencer between the MEM-stage pipeline logic and `data_mem`. It drives the data memory's address, write-data, write-control and read-control inputs and consumes its `spo` read port. Aligned accesses pass straight through in one cycle. Misaligned halfword and word accesses are split into sequential byte accesses while the pipeline is stalled, and loads are reassembled and sign- or zero-extended.

---
 rtl/lsu_misalign_unit_pkg.sv | 63 ++++++
 rtl/lsu_misalign_unit_load_ext.sv | 26 ++
 rtl/lsu_misalign_unit.sv | 165 ++++++++++++++++
 tb/tb_lsu_misalign_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_misalign_unit_pkg.sv
// lsu_pkg: shared encodings for the load/store misalignment sequencer.
//   - access size codes as presented by the MEM stage
//   - data_mem write-control and read-control codes
//   - sequencer state enum
//   - small helpers that map a request onto data_mem control codes
package lsu_pkg;

    localparam logic [1:0] SZ_B    = 2'd0;
    localparam logic [1:0] SZ_H    = 2'd1;
    localparam logic [1:0] SZ_W    = 2'd2;

    localparam logic [1:0] WE_NONE = 2'd0;
    localparam logic [1:0] WE_W    = 2'd1;
    localparam logic [1:0] WE_H    = 2'd2;
    localparam logic [1:0] WE_B    = 2'd3;

    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LW   = 3'd1;
    localparam logic [2:0] RD_LHU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LBU  = 3'd4;
    localparam logic [2:0] RD_LB   = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DONE  = 2'd2
    } lsu_state_e;

    // Size code 3 is handled as a word everywhere (falls into default).
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = (lo[0] == 1'b0);
            default: is_aligned = (lo == 2'b00);
        endcase
    endfunction

    // Index of the final byte of a split access (only half/word are ever split).
    function automatic logic [1:0] last_byte(input logic [1:0] size);
        case (size)
            SZ_H:    last_byte = 2'd1;
            default: last_byte = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] we_code(input logic [1:0] size);
        case (size)
            SZ_B:    we_code = WE_B;
            SZ_H:    we_code = WE_H;
            default: we_code = WE_W;
        endcase
    endfunction

    function automatic logic [2:0] rd_code(input logic [1:0] size, input logic uns);
        case (size)
            SZ_B:    rd_code = uns ? RD_LBU : RD_LB;
            SZ_H:    rd_code = uns ? RD_LHU : RD_LH;
            default: rd_code = RD_LW;
        endcase
    endfunction

endpackage

// File: rtl/lsu_misalign_unit_load_ext.sv
// lsu_load_ext: combinational size/sign extender for reassembled loads.
//   size        in  2  : access size code (SZ_B / SZ_H / word)
//   is_unsigned in  1  : zero-extend instead of sign-extend
//   raw         in  32 : right-aligned raw load bytes
//   ext         out 32 : extended load result
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    // Extend from bit 7 (byte) or bit 15 (half); words pass unchanged.
    always_comb begin
        case (size)
            SZ_B:    ext = is_unsigned ? {24'h000000, raw[7:0]}
                                       : {{24{raw[7]}}, raw[7:0]};
            SZ_H:    ext = is_unsigned ? {16'h0000, raw[15:0]}
                                       : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_unit.sv
// lsu_misalign_unit: load/store sequencer between the MEM stage and data_mem.
// Aligned accesses pass straight through in the request cycle. Misaligned
// half/word accesses are split into byte accesses while the pipeline is
// stalled; loads are reassembled and extended in a one-cycle DONE state.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/store/size/unsigned/addr/wdata : MEM-stage request
//   stall                    : freeze the pipeline this cycle
//   ld_data, ld_valid        : extended load result and its strobe
//   dm_a, dm_d, dm_we, dm_rd_ctrl : data_mem control
//   dm_spo                   : data_mem combinational read data
module lsu_misalign_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic [ADDR_W-1:0] dm_a,
    output logic [31:0]       dm_d,
    output logic [1:0]        dm_we,
    output logic [2:0]        dm_rd_ctrl,
    input  logic [31:0]       dm_spo
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              store_q, store_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       ext_s;

    lsu_load_ext u_load_ext (
        .size        (size_q),
        .is_unsigned (uns_q),
        .raw         (asm_q),
        .ext         (ext_s)
    );

    // Next-state and data_mem/pipeline output decode.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        store_d    = store_q;
        asm_d      = asm_q;
        stall      = 1'b0;
        ld_data    = 32'h00000000;
        ld_valid   = 1'b0;
        dm_a       = {ADDR_W{1'b0}};
        dm_d       = 32'h00000000;
        dm_we      = WE_NONE;
        dm_rd_ctrl = RD_NONE;

        // Outputs are forced idle while reset is held so no byte of an
        // abandoned sequence commits at the resetting edge.
        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!req_valid) begin
                        state_d = IDLE;
                    end else if (is_aligned(req_size, req_addr[1:0])) begin
                        dm_a = req_addr;
                        dm_d = req_wdata;
                        if (req_store) begin
                            dm_we = we_code(req_size);
                        end else begin
                            dm_rd_ctrl = rd_code(req_size, req_unsigned);
                            ld_data    = dm_spo;
                            ld_valid   = 1'b1;
                        end
                    end else begin
                        // Capture the request and issue byte 0 right away.
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        store_d = req_store;
                        k_d     = 2'd1;
                        state_d = SPLIT;
                        stall   = 1'b1;
                        dm_a    = req_addr;
                        if (req_store) begin
                            dm_we = WE_B;
                            dm_d  = {24'h000000, req_wdata[7:0]};
                        end else begin
                            dm_rd_ctrl = RD_LBU;
                            asm_d      = {24'h000000, dm_spo[7:0]};
                        end
                    end
                end
                SPLIT: begin
                    stall = 1'b1;
                    dm_a  = addr_q + ADDR_W'(k_q);
                    if (store_q) begin
                        dm_we = WE_B;
                        dm_d  = {24'h000000, wdata_q[{k_q, 3'b000} +: 8]};
                    end else begin
                        dm_rd_ctrl                  = RD_LBU;
                        asm_d[{k_q, 3'b000} +: 8]   = dm_spo[7:0];
                    end
                    if (k_q == last_byte(size_q)) begin
                        k_d     = 2'd0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
                DONE: begin
                    // The request inputs still show the retiring instruction.
                    if (!store_q) begin
                        ld_data  = ext_s;
                        ld_valid = 1'b1;
                    end else begin
                        ld_valid = 1'b0;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer state and captured request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= 32'h00000000;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            asm_q   <= 32'h00000000;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            store_q <= store_d;
            asm_q   <= asm_d;
        end
    end

endmodule

// File: tb/tb_lsu_misalign_unit.sv
// Self-checking bench for lsu_misalign_unit: a byte-array data_mem stands in
// for the real memory, and a separate byte-level reference memory predicts
// every load result, stall count and final memory image.
module tb_lsu_misalign_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        stall, ld_valid;
    logic [31:0] ld_data, dm_d, dm_spo;
    logic [9:0]  dm_a;
    logic [1:0]  dm_we;
    logic [2:0]  dm_rd_ctrl;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] dmem    [0:1023] = '{default: 8'h00};
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

    lsu_misalign_unit #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
        .dm_a(dm_a), .dm_d(dm_d), .dm_we(dm_we), .dm_rd_ctrl(dm_rd_ctrl), .dm_spo(dm_spo)
    );

    always #5 clk = ~clk;

    // data_mem stand-in: little-endian byte writes at the clock edge
    always @(posedge clk) begin
        case (dm_we)
            2'd1: for (int i = 0; i < 4; i++) dmem[10'(dm_a + 10'(i))] <= dm_d[8*i +: 8];
            2'd2: for (int i = 0; i < 2; i++) dmem[10'(dm_a + 10'(i))] <= dm_d[8*i +: 8];
            2'd3: dmem[dm_a] <= dm_d[7:0];
            default: ;
        endcase
    end

    logic [31:0] spo_word;
    // data_mem stand-in: combinational read port
    always_comb begin
        spo_word = {dmem[10'(dm_a + 10'd3)], dmem[10'(dm_a + 10'd2)],
                    dmem[10'(dm_a + 10'd1)], dmem[dm_a]};
        case (dm_rd_ctrl)
            3'd1:    dm_spo = spo_word;
            3'd2:    dm_spo = {16'h0000, spo_word[15:0]};
            3'd3:    dm_spo = {{16{spo_word[15]}}, spo_word[15:0]};
            3'd4:    dm_spo = {24'h000000, spo_word[7:0]};
            3'd5:    dm_spo = {{24{spo_word[7]}}, spo_word[7:0]};
            default: dm_spo = 32'h00000000;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int exp_stalls(input logic [1:0] sz, input logic [9:0] ad);
        int n = nbytes(sz);
        return ((int'(ad) % n) == 0) ? 0 : n;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [9:0] ad, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[(int'(ad) + i) % 1024] = wd[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic un, input logic [9:0] ad);
        longint v = 0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[(int'(ad) + i) % 1024]) << (8 * i));
        if (!un && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // Drive one request until the pipeline is released; returns observations.
    task automatic run_access(input logic st, input logic [1:0] sz, input logic un,
                              input logic [9:0] ad, input logic [31:0] wd,
                              output int stalls, output logic got_valid,
                              output logic [31:0] got_data, output logic ok);
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        stalls = 0; ok = 1'b0; got_valid = 1'b0; got_data = 32'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            else begin got_valid = ld_valid; got_data = ld_data; ok = 1'b1; end
            @(posedge clk); #1;
            if (ok) break;
        end
        req_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 10'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({stall, ld_valid, dm_we, dm_rd_ctrl} !== 7'd0 || dm_a !== 10'd0 || dm_d !== 32'd0)
            $display("FAIL reset_idle: stall=%0d ld_valid=%0d we=%0d rd=%0d a=%h d=%h, required all 0",
                     stall, ld_valid, dm_we, dm_rd_ctrl, dm_a, dm_d);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_aligned_load;
        int s; logic v, ok; logic [31:0] d;
        run_access(1'b1, 2'd2, 1'b0, 10'h004, 32'hDEADBEEF, s, v, d, ok); ref_store(2'd2, 10'h004, 32'hDEADBEEF);
        total_cnt++;
        if (!ok || s !== 0) $display("FAIL aligned_store_stall: got %0d (ok=%0d), required 0", s, ok);
        else pass_cnt++;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h004;
        @(negedge clk);
        total_cnt++;
        if (dm_rd_ctrl !== 3'd1 || ld_data !== 32'hDEADBEEF || stall !== 1'b0 || ld_valid !== 1'b1)
            $display("FAIL aligned_lw: rd=%0d data=%h stall=%0d valid=%0d, required 1 DEADBEEF 0 1",
                     dm_rd_ctrl, ld_data, stall, ld_valid);
        else pass_cnt++;
        @(posedge clk); #1; req_valid = 1'b0;
        run_access(1'b1, 2'd2, 1'b0, 10'h004, 32'h0, s, v, d, ok); ref_store(2'd2, 10'h004, 32'h0);
    endtask

    task automatic test_misaligned_store;
        logic [7:0] bytes_exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        int s; logic v, ok; logic [31:0] d;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 10'h003; req_wdata = 32'h11223344;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total_cnt++;
            if (stall !== 1'b1 || dm_we !== 2'd3 || dm_a !== 10'(3 + k) || dm_d !== {24'h0, bytes_exp[k]})
                $display("FAIL mis_store_byte%0d: stall=%0d we=%0d a=%h d=%h, required 1 3 %h %h",
                         k, stall, dm_we, dm_a, dm_d, 10'(3 + k), bytes_exp[k]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b0 || dm_we !== 2'd0 || ld_valid !== 1'b0)
            $display("FAIL mis_store_done: stall=%0d we=%0d valid=%0d, required 0 0 0", stall, dm_we, ld_valid);
        else pass_cnt++;
        @(posedge clk); #1; req_valid = 1'b0;
        ref_store(2'd2, 10'h003, 32'h11223344);
        run_access(1'b0, 2'd0, 1'b1, 10'h003, 32'h0, s, v, d, ok);
        total_cnt++;
        if (!ok || d !== 32'h00000044) $display("FAIL mis_store_byte3: got %h, required 00000044", d);
        else pass_cnt++;
        run_access(1'b0, 2'd2, 1'b0, 10'h004, 32'h0, s, v, d, ok);
        total_cnt++;
        if (!ok || d !== 32'h00112233) $display("FAIL mis_store_word1: got %h, required 00112233", d);
        else pass_cnt++;
    endtask

    task automatic test_misaligned_load;
        int s; logic v, ok; logic [31:0] d;
        run_access(1'b0, 2'd2, 1'b0, 10'h003, 32'h0, s, v, d, ok);
        total_cnt++;
        if (!ok || s !== 4 || v !== 1'b1 || d !== 32'h11223344)
            $display("FAIL mis_lw: stalls=%0d valid=%0d data=%h, required 4 1 11223344", s, v, d);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ld_valid !== 1'b0) $display("FAIL mis_lw_valid_once: got %0d, required 0", ld_valid);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_half_load;
        int s; logic v, ok; logic [31:0] d;
        run_access(1'b1, 2'd0, 1'b0, 10'h001, 32'h80, s, v, d, ok); ref_store(2'd0, 10'h001, 32'h80);
        run_access(1'b1, 2'd0, 1'b0, 10'h002, 32'hFF, s, v, d, ok); ref_store(2'd0, 10'h002, 32'hFF);
        run_access(1'b0, 2'd1, 1'b0, 10'h001, 32'h0, s, v, d, ok);
        total_cnt++;
        if (!ok || s !== 2 || v !== 1'b1 || d !== 32'hFFFFFF80)
            $display("FAIL mis_lh: stalls=%0d valid=%0d data=%h, required 2 1 FFFFFF80", s, v, d);
        else pass_cnt++;
        run_access(1'b0, 2'd1, 1'b1, 10'h001, 32'h0, s, v, d, ok);
        total_cnt++;
        if (!ok || s !== 2 || v !== 1'b1 || d !== 32'h0000FF80)
            $display("FAIL mis_lhu: stalls=%0d valid=%0d data=%h, required 2 1 0000FF80", s, v, d);
        else pass_cnt++;
    endtask

    task automatic test_wrap;
        int s; logic v, ok; logic [31:0] d;
        run_access(1'b1, 2'd1, 1'b0, 10'h3FF, 32'h0000ABCD, s, v, d, ok);
        ref_store(2'd1, 10'h3FF, 32'h0000ABCD);
        total_cnt++;
        if (!ok || s !== 2 || dmem[10'h3FF] !== 8'hCD || dmem[10'h000] !== 8'hAB ||
            dmem[10'h3FE] !== 8'h00 || dmem[10'h001] !== 8'h80)
            $display("FAIL wrap_sh: stalls=%0d m3FF=%h m000=%h m3FE=%h m001=%h, required 2 CD AB 00 80",
                     s, dmem[10'h3FF], dmem[10'h000], dmem[10'h3FE], dmem[10'h001]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int s; logic v, ok; logic [31:0] d;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 10'h101; req_wdata = 32'hA1B2C3D4;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1; req_valid = 1'b0;              // cycle that would issue k=2
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (stall !== 1'b0 || dm_we !== 2'd0 || ld_valid !== 1'b0)
            $display("FAIL reset_mid_idle: stall=%0d we=%0d valid=%0d, required 0 0 0", stall, dm_we, ld_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        ref_mem[10'h101] = 8'hD4; ref_mem[10'h102] = 8'hC3;
        total_cnt++;
        if (dmem[10'h101] !== 8'hD4 || dmem[10'h102] !== 8'hC3 ||
            dmem[10'h103] !== 8'h00 || dmem[10'h104] !== 8'h00)
            $display("FAIL reset_mid_bytes: %h %h %h %h, required D4 C3 00 00",
                     dmem[10'h101], dmem[10'h102], dmem[10'h103], dmem[10'h104]);
        else pass_cnt++;
        run_access(1'b0, 2'd1, 1'b1, 10'h101, 32'h0, s, v, d, ok);
        total_cnt++;
        if (!ok || s !== 2 || d !== 32'h0000C3D4)
            $display("FAIL reset_mid_after: stalls=%0d data=%h, required 2 0000C3D4", s, d);
        else pass_cnt++;
    endtask

    task automatic test_random;
        int s, es; logic v, ok; logic [31:0] d, ed;
        logic st, un; logic [1:0] sz; logic [9:0] ad; logic [31:0] wd;
        for (int n = 0; n < 120; n++) begin
            st = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1)); ad = 10'($urandom_range(0, 1023));
            wd = $urandom;
            es = exp_stalls(sz, ad);
            ed = ref_load(sz, un, ad);
            run_access(st, sz, un, ad, wd, s, v, d, ok);
            total_cnt++;
            if (st) begin
                ref_store(sz, ad, wd);
                if (!ok || s !== es || v !== 1'b0)
                    $display("FAIL rand_store%0d sz=%0d a=%h: stalls=%0d valid=%0d, required %0d 0", n, sz, ad, s, v, es);
                else pass_cnt++;
            end else begin
                if (!ok || s !== es || v !== 1'b1 || d !== ed)
                    $display("FAIL rand_load%0d sz=%0d u=%0d a=%h: stalls=%0d valid=%0d data=%h, required %0d 1 %h",
                             n, sz, un, ad, s, v, d, es, ed);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_mem_image;
        int bad = 0;
        for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL mem_image: %0d bytes differ, required 0", bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_misaligned_store();
        test_misaligned_load();
        test_half_load();
        test_wrap();
        test_reset_mid();
        test_random();
        test_mem_image();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
